// File: rtl/ifetch_npc_pkg.sv
// Shared encodings, defaults and helpers for the miniRV next-PC / instruction-fetch stage.
// Optional feature macro used by the stage: PC_MISALIGN_CHK_EN.
package ifetch_npc_pkg;

   localparam int unsigned XLEN_DEFAULT     = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      NPC_PC4  = 2'd0,
      NPC_BR   = 2'd1,
      NPC_JAL  = 2'd2,
      NPC_JALR = 2'd3
   } npc_op_e;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_HOLD = 3'd3,
      S_HALT = 3'd4
   } fetch_state_e;

   // One decoded-side buffer entry: the instruction word and the PC it was fetched from.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   function automatic logic [31:0] seq_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/ifetch_npc_if.sv
// Instruction-memory bus plus the fetch-to-decode valid/ready channel of the fetch stage.
// master = fetch stage side, slave = memory/decode side.
interface ifetch_npc_if
   import ifetch_npc_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
);

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;

   logic            if_valid;
   logic [XLEN-1:0] if_pc;
   logic [XLEN-1:0] if_inst;
   logic            if_ready;

   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata,
      output if_valid, if_pc, if_inst,
      input  if_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata,
      input  if_valid, if_pc, if_inst,
      output if_ready
   );

endinterface

// File: rtl/ifetch_npc_npc_calc.sv
// npc_calc: combinational branch/jump resolution (target, redirect, link address) for the fetch stage.
// With PC_MISALIGN_CHK_EN undefined the low two target bits are forced to zero.
module npc_calc
   import ifetch_npc_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
)
(
   input  logic            ex_valid_i,
   input  logic [XLEN-1:0] ex_pc_i,
   input  logic [XLEN-1:0] ex_imm_i,
   input  npc_op_e         npc_op_i,
   input  logic            alu_f_i,
   input  logic [XLEN-1:0] alu_c_i,
   output logic [XLEN-1:0] target_o,
   output logic            redirect_o,
   output logic [XLEN-1:0] link_addr_o
);

   logic [XLEN-1:0] raw_target;
   logic            unused_bits;

   always_comb begin
      raw_target = ex_pc_i + ex_imm_i;
      redirect_o = 1'b0;
      case (npc_op_i)
         NPC_BR:   redirect_o = ex_valid_i & alu_f_i;
         NPC_JAL:  redirect_o = ex_valid_i;
         NPC_JALR: begin
            raw_target = {alu_c_i[XLEN-1:1], 1'b0};
            redirect_o = ex_valid_i;
         end
         default:  redirect_o = 1'b0;
      endcase
   end

`ifdef PC_MISALIGN_CHK_EN
   assign target_o    = raw_target;
   assign unused_bits = alu_c_i[0];
`else
   // Without the checker a misaligned target is silently word-aligned.
   assign target_o    = {raw_target[XLEN-1:2], 2'b00};
   assign unused_bits = ^{alu_c_i[0], raw_target[1:0]};
`endif

   assign link_addr_o = seq_pc(ex_pc_i);

endmodule

// File: rtl/ifetch_npc.sv
// ifetch_npc: miniRV next-PC and instruction-fetch stage with one outstanding fetch and a one-entry decode buffer.
// Macro PC_MISALIGN_CHK_EN adds misalign_err_o and a halt state for misaligned redirect targets.
module ifetch_npc
   import ifetch_npc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned XLEN     = XLEN_DEFAULT
)
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid_i,
   input  logic [XLEN-1:0] ex_pc_i,
   input  logic [XLEN-1:0] ex_imm_i,
   input  logic [1:0]      npc_op_i,
   input  logic            alu_f_i,
   input  logic [XLEN-1:0] alu_c_i,
   output logic            redirect_o,
   output logic [XLEN-1:0] link_addr_o,
`ifdef PC_MISALIGN_CHK_EN
   output logic            misalign_err_o,
`endif
   ifetch_npc_if.master    bus
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   fetch_entry_t    buf_q, buf_d;
   logic            buf_valid_q, buf_valid_d;
   logic            kill_q, kill_d;

   logic [XLEN-1:0] target;
   logic            redirect;
   logic            drain;
   logic            req_en;
   logic            gnt_acc;
   logic            misalign;

   npc_calc #(.XLEN(XLEN)) u_npc_calc (
      .ex_valid_i  (ex_valid_i),
      .ex_pc_i     (ex_pc_i),
      .ex_imm_i    (ex_imm_i),
      .npc_op_i    (npc_op_e'(npc_op_i)),
      .alu_f_i     (alu_f_i),
      .alu_c_i     (alu_c_i),
      .target_o    (target),
      .redirect_o  (redirect),
      .link_addr_o (link_addr_o)
   );

   assign redirect_o = redirect;

   // A request may go out only if the buffer is empty or is being consumed this very cycle.
   assign drain   = buf_valid_q & bus.if_ready;
   assign req_en  = (state_q == S_REQ) & (~buf_valid_q | bus.if_ready);
   assign gnt_acc = req_en & bus.imem_gnt;

   assign bus.imem_req  = req_en;
   assign bus.imem_addr = req_en ? pc_q : '0;
   assign bus.if_valid  = buf_valid_q;
   assign bus.if_pc     = buf_q.pc;
   assign bus.if_inst   = buf_q.inst;

`ifdef PC_MISALIGN_CHK_EN
   logic misalign_q, misalign_d;
   assign misalign       = redirect & (target[1:0] != 2'b00);
   assign misalign_err_o = misalign_q;
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      buf_d       = buf_q;
      buf_valid_d = buf_valid_q;
      kill_d      = kill_q;
`ifdef PC_MISALIGN_CHK_EN
      misalign_d  = misalign_q;
`endif

      if (drain) begin
         buf_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (gnt_acc) begin
               state_d  = S_WAIT;
               pc_d     = seq_pc(pc_q);
               req_pc_d = pc_q;
            end else if (!req_en) begin
               state_d = S_HOLD;
            end
         end
         S_WAIT: begin
            if (bus.imem_rvalid) begin
               if (kill_q) begin
                  kill_d = 1'b0;
               end else begin
                  buf_d       = '{pc: req_pc_q, inst: bus.imem_rdata};
                  buf_valid_d = 1'b1;
               end
               state_d = (~buf_valid_q | drain) ? S_REQ : S_HOLD;
            end
         end
         S_HOLD: begin
            if (~buf_valid_q | drain) begin
               state_d = S_REQ;
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase

      // A redirect overrides everything decided above; a granted or in-flight fetch becomes a kill.
      if (redirect && (state_q != S_HALT)) begin
         buf_valid_d = 1'b0;
         buf_d       = '0;
         if (misalign) begin
            state_d = S_HALT;
            pc_d    = pc_q;
            kill_d  = 1'b0;
`ifdef PC_MISALIGN_CHK_EN
            misalign_d = 1'b1;
`endif
         end else begin
            pc_d = target;
            case (state_q)
               S_WAIT: begin
                  if (bus.imem_rvalid) begin
                     kill_d  = 1'b0;
                     state_d = S_REQ;
                  end else begin
                     kill_d  = 1'b1;
                     state_d = S_WAIT;
                  end
               end
               S_REQ: begin
                  if (gnt_acc) begin
                     kill_d  = 1'b1;
                     state_d = S_WAIT;
                  end else begin
                     state_d = S_REQ;
                  end
               end
               default: state_d = S_REQ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         req_pc_q    <= '0;
         buf_q       <= '0;
         buf_valid_q <= 1'b0;
         kill_q      <= 1'b0;
`ifdef PC_MISALIGN_CHK_EN
         misalign_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         buf_q       <= buf_d;
         buf_valid_q <= buf_valid_d;
         kill_q      <= kill_d;
`ifdef PC_MISALIGN_CHK_EN
         misalign_q  <= misalign_d;
`endif
      end
   end

endmodule
